dsram_like_bridge: RTL and testbench
====================================

// Module: dsram_like_bridge
// PURPOSE
//  Bridges the CPU memory-stage data port (one-cycle SRAM style: en/wen/addr/wdata/rdata) to a
//  sram-like bus (req/addr_ok/data_ok). Sits directly downstream of the datapath memory stage.
//  Holds the pipeline with stall_o until the transaction completes, then buffers rdata until the
//  pipeline advances, so no access is ever issued twice.
// PARAMETERS
//  TIMEOUT_CYCLES  255  data_ok watchdog limit in cycles (used only with DBRIDGE_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock; all state changes on posedge
//  rst          in   1   synchronous, active-high reset
//  mem_en       in   1   CPU requests an access this cycle
//  mem_wen      in   4   byte write enables; 4'b0000 = read
//  mem_size     in   2   0=byte 1=half 2=word (read or write)
//  mem_addr     in   32  byte address (already aligned-checked upstream)
//  mem_wdata    in   32  store data, byte-lane positioned
//  mem_cancel   in   1   exception flush of the memory stage this cycle
//  pipe_stall   in   1   stall from any other source (hazard unit, icache)
//  mem_rdata    out  32  load data; valid while state==DONE
//  stall_o      out  1   hold the pipeline (access outstanding)
//  data_req     out  1   bus request
//  data_wr      out  1   1=write
//  data_size    out  2   copy of mem_size
//  data_addr    out  32  copy of mem_addr, held stable while data_req=1
//  data_wdata   out  32  copy of mem_wdata, held stable while data_req=1
//  data_addr_ok in   1   bus accepted address this cycle
//  data_data_ok in   1   bus returns data / write ack this cycle
//  data_rdata   in   32  bus read data, valid with data_data_ok
//  bus_err_o    out  1   sticky watchdog error (0 when DBRIDGE_TIMEOUT_EN undefined)
// BEHAVIOUR
//  Reset: state=IDLE; stall_o=0, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0,
//   mem_rdata=0, bus_err_o=0.
//  FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE.
//   IDLE: mem_en & ~mem_cancel -> capture addr/wdata/size/wr=|mem_wen into regs, go REQ.
//     stall_o is combinationally 1 in that cycle (mem_en & ~mem_cancel & IDLE).
//   REQ: data_req=1; fields stable. addr_ok & data_ok same cycle -> latch rdata, go DONE.
//     addr_ok alone -> WAIT. mem_cancel in REQ before addr_ok -> drop, go IDLE, req deasserts.
//   WAIT: data_req=0; on data_ok latch data_rdata (writes: latch 0), go DONE. mem_cancel ignored:
//     an accepted access always drains; after drain, DONE is left on the next cycle.
//   DONE: stall_o=0; mem_rdata holds latched value; ~pipe_stall -> IDLE (pipeline advanced);
//     pipe_stall=1 -> stay DONE, no re-issue even though mem_en stays 1.
//  stall_o = 1 in REQ and WAIT, and in IDLE per above; 0 in DONE.
//  Latency: zero-wait bus (addr_ok & data_ok in REQ cycle) -> 2 stall cycles; 1 access per 3 clocks min.
//  data_ok seen in IDLE/DONE (spurious) is ignored. rst mid-transaction returns to IDLE at once;
//   the bus side is reset together with the bridge, so no drain is needed.
// CONFIGURATION
//  DBRIDGE_TIMEOUT_EN defined: 8-bit-or-wider counter clears on entering REQ, increments in REQ/WAIT;
//   reaching TIMEOUT_CYCLES forces DONE with mem_rdata=32'hDEAD_BEEF and sets bus_err_o
//   (cleared only by rst). Undefined: no counter, bus_err_o tied 0, bridge waits forever.
// TESTING
//  Word read, addr_ok+data_ok same cycle, rdata=32'h1234_5678 -> stall_o 2 cycles, mem_rdata=32'h1234_5678 in DONE.
//  Byte write wen=4'b0100 addr=32'h8000_0002, addr_ok after 3 cycles, data_ok 2 later -> data_wr=1,
//   data_size=0, data_addr/data_wdata stable 4 req cycles, stall_o released the cycle after data_ok.
//  Read completes while pipe_stall=1 for 5 cycles, mem_en held -> exactly one data_req pulse train,
//   state DONE 5 cycles, back to IDLE when pipe_stall drops.
//  mem_cancel in REQ before addr_ok -> req drops next cycle, IDLE; mem_cancel in WAIT -> still
//   waits for data_ok, no new request.
//  rst asserted in WAIT -> next cycle all outputs at reset values, state IDLE.
//  DBRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, bus never returns data_ok -> bus_err_o=1 after 16 cycles,
//   mem_rdata=32'hDEAD_BEEF, stall_o=0.

Source files
------------

// File: rtl/dsram_like_bridge_if.sv
// sram-like data bus between the memory-stage bridge (master) and the bus/cache side (slave).
interface dsram_like_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dsram_like_bridge.sv
// Memory-stage data port to sram-like bus bridge: stalls the pipeline for exactly one access and
// holds the result until the pipeline advances. Optional data_ok watchdog: DBRIDGE_TIMEOUT_EN.
module dsram_like_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en,
  input  logic [3:0]          mem_wen,
  input  logic [1:0]          mem_size,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic                mem_cancel,
  input  logic                pipe_stall,
  output logic [31:0]         mem_rdata,
  output logic                stall_o,
  dsram_like_bridge_if.master bus,
  output logic                bus_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        flush_q, flush_d;

  logic        accept;
  logic        busy;
  logic [31:0] bus_load;

  assign accept   = mem_en & ~mem_cancel;
  assign busy     = (state_q == S_REQ) | (state_q == S_WAIT);
  assign bus_load = wr_q ? 32'h0 : bus.data_rdata;

`ifdef DBRIDGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // NOTE: every *_d is given its held value first, so no branch of the case can infer a latch.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    flush_d = flush_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = |mem_wen;
          size_d  = mem_size;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          flush_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.data_addr_ok) begin
          // A flush in the acceptance cycle is too late to drop the access; it only drains.
          flush_d = mem_cancel;
          if (bus.data_data_ok) begin
            rdata_d = bus_load;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (mem_cancel) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_cancel) flush_d = 1'b1;
        if (bus.data_data_ok) begin
          rdata_d = bus_load;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A flushed access has no pipeline stage waiting on it, so it never holds DONE.
        if (!pipe_stall || flush_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DBRIDGE_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (busy && (state_d == S_REQ || state_d == S_WAIT) && cnt_q == CNT_LAST) begin
      state_d = S_DONE;
      rdata_d = 32'hDEAD_BEEF;
      err_d   = 1'b1;
    end
`endif
  end

  // NOTE: non-blocking assignments make every flop sample the pre-edge *_d values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      flush_q <= 1'b0;
`ifdef DBRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      flush_q <= flush_d;
`ifdef DBRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.data_req   = (state_q == S_REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

  assign stall_o   = busy | ((state_q == S_IDLE) & accept);
  assign mem_rdata = rdata_q;

`ifdef DBRIDGE_TIMEOUT_EN
  assign bus_err_o = err_q;
`else
  // Watchdog absent: the parameter is kept so both builds share one instantiation.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dsram_like_bridge.sv
// Self-checking bench for dsram_like_bridge: directed spec cases plus randomized accesses,
// expectations derived per access from its bus delays (addr_ok/data_ok) and pipeline stall.
module tb_dsram_like_bridge;
`ifdef DBRIDGE_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 16;
`else
  localparam int unsigned TO_CYCLES = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_cancel;
  logic        pipe_stall;
  logic [31:0] mem_rdata;
  logic        stall_o;
  logic        bus_err_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata;
  logic        exp_err;

  dsram_like_bridge_if bus ();

  dsram_like_bridge #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_cancel(mem_cancel),
    .pipe_stall(pipe_stall),
    .mem_rdata (mem_rdata),
    .stall_o   (stall_o),
    .bus       (bus),
    .bus_err_o (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
  endtask

  // One access: addr_ok a_dly REQ cycles after the request, data_ok d_dly cycles after addr_ok,
  // then p_cyc cycles of pipe_stall in DONE before the pipeline advances.
  task automatic access(input logic [3:0] wen, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd, input int a_dly,
                        input int d_dly, input int p_cyc, input bit cancel_wait);
    int last_k;
    last_k = 1 + a_dly + d_dly;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      mem_en = 1'b1;
      if (k == 0) begin
        mem_wen   = wen;
        mem_size  = size;
        mem_addr  = addr;
        mem_wdata = wdata;
      end else begin
        mem_wen   = 4'($urandom);
        mem_size  = 2'($urandom_range(0, 2));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
      mem_cancel       = cancel_wait && (k >= 2 + a_dly);
      pipe_stall       = 1'($urandom_range(0, 1));
      bus.data_addr_ok = (k == 1 + a_dly);
      bus.data_data_ok = (k == last_k) || (k == 0 && $urandom_range(0, 1) == 1);
      bus.data_rdata   = (k == last_k) ? rd : $urandom;
      #1;
      check("stall_busy", stall_o, 1);
      check("req", bus.data_req, (k >= 1 && k <= 1 + a_dly));
      if (k >= 1 && k <= 1 + a_dly) begin
        check("data_wr", bus.data_wr, |wen);
        check("data_size", bus.data_size, size);
        check("data_addr", bus.data_addr, addr);
        check("data_wdata", bus.data_wdata, wdata);
      end
    end
    exp_rdata = (|wen) ? 32'h0 : rd;
    for (int j = 0; j <= p_cyc; j++) begin
      @(negedge clk);
      mem_en           = !cancel_wait;
      mem_cancel       = 1'b0;
      pipe_stall       = (j < p_cyc);
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'($urandom_range(0, 1));
      bus.data_rdata   = $urandom;
      #1;
      check("stall_done", stall_o, 0);
      check("req_done", bus.data_req, 0);
      check("rdata_done", mem_rdata, exp_rdata);
      check("bus_err", bus_err_o, exp_err);
    end
  endtask

  // Idle cycles; any enable here arrives already flushed and must not start an access.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_en           = 1'($urandom_range(0, 1));
      mem_cancel       = mem_en;
      mem_wen          = 4'($urandom);
      mem_addr         = $urandom;
      pipe_stall       = 1'($urandom_range(0, 1));
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'($urandom_range(0, 1));
      bus.data_rdata   = $urandom;
      #1;
      check("stall_idle", stall_o, 0);
      check("req_idle", bus.data_req, 0);
    end
  endtask

  // Flush arrives in REQ cycle c (c >= 1) while addr_ok is still low.
  task automatic cancel_req(input int c);
    for (int k = 0; k <= c; k++) begin
      @(negedge clk);
      mem_en           = 1'b1;
      mem_wen          = 4'b0000;
      mem_size         = 2'd2;
      mem_addr         = $urandom;
      mem_cancel       = (k == c);
      pipe_stall       = 1'b0;
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      #1;
      check("stall_creq", stall_o, 1);
      check("req_creq", bus.data_req, (k >= 1));
    end
    idle(2);
  endtask

  initial begin
    logic [3:0] wen;
    int         a;
    int         d;
    int         p;
    bit         cw;

    rst              = 1'b1;
    mem_en           = 1'b0;
    mem_wen          = 4'b0;
    mem_size         = 2'd0;
    mem_addr         = 32'h0;
    mem_wdata        = 32'h0;
    mem_cancel       = 1'b0;
    pipe_stall       = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    exp_rdata        = 32'h0;
    exp_err          = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_req", bus.data_req, 0);
    check("rst_wr", bus.data_wr, 0);
    check("rst_size", bus.data_size, 0);
    check("rst_addr", bus.data_addr, 0);
    check("rst_wdata", bus.data_wdata, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_err", bus_err_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait word read: two stall cycles, then one access every three clocks
    access(4'b0000, 2'd2, 32'h0000_1000, 32'h0, 32'h1234_5678, 0, 0, 0, 0);
    access(4'b0000, 2'd2, 32'h0000_1004, 32'h0, 32'hCAFE_0001, 0, 0, 0, 0);
    // Byte write with slow address and data handshakes
    access(4'b0100, 2'd0, 32'h8000_0002, 32'h00AB_0000, $urandom, 3, 2, 0, 0);
    // Read completing under a five-cycle external stall with mem_en held
    access(4'b0000, 2'd2, 32'h0000_2000, 32'h0, 32'h5A5A_A5A5, 1, 1, 5, 0);
    idle(2);
    // Flush before addr_ok drops the request; flush in WAIT still drains
    cancel_req(1);
    cancel_req(3);
    access(4'b0000, 2'd1, 32'h0000_3002, 32'h0, 32'h0000_BEEF, 1, 3, 0, 1);
    idle(1);

    // rst while waiting for data_ok
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      mem_en           = 1'b1;
      mem_wen          = 4'b1111;
      mem_size         = 2'd2;
      mem_addr         = 32'h7000_0010;
      mem_wdata        = 32'h1357_9BDF;
      mem_cancel       = 1'b0;
      pipe_stall       = 1'b0;
      bus.data_addr_ok = (k == 1);
      bus.data_data_ok = 1'b0;
      rst              = (k == 3);
      #1;
      check("stall_prerst", stall_o, 1);
    end
    @(negedge clk);
    rst    = 1'b0;
    mem_en = 1'b0;
    #1;
    exp_rdata = 32'h0;
    check("wrst_stall", stall_o, 0);
    check("wrst_req", bus.data_req, 0);
    check("wrst_wr", bus.data_wr, 0);
    check("wrst_size", bus.data_size, 0);
    check("wrst_addr", bus.data_addr, 0);
    check("wrst_wdata", bus.data_wdata, 0);
    check("wrst_rdata", mem_rdata, exp_rdata);
    check("wrst_err", bus_err_o, 0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      a   = $urandom_range(0, 4);
      d   = $urandom_range(0, 4);
      cw  = (d > 0) && ($urandom_range(0, 5) == 0);
      p   = cw ? 0 : $urandom_range(0, 3);
      access(wen, 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom, a, d, p, cw);
      idle($urandom_range(0, 2));
    end

`ifdef DBRIDGE_TIMEOUT_EN
    // Bus never responds: the watchdog ends the access on its own
    for (int k = 0; k <= int'(TO_CYCLES); k++) begin
      @(negedge clk);
      mem_en           = 1'b1;
      mem_wen          = 4'b0000;
      mem_size         = 2'd2;
      mem_addr         = 32'h0000_4000;
      mem_cancel       = 1'b0;
      pipe_stall       = 1'b1;
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      #1;
      check("stall_to", stall_o, 1);
    end
    exp_rdata = 32'hDEAD_BEEF;
    exp_err   = 1'b1;
    @(negedge clk);
    pipe_stall = 1'b0;
    #1;
    check("to_stall", stall_o, 0);
    check("to_rdata", mem_rdata, exp_rdata);
    check("to_err", bus_err_o, exp_err);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
